// File: rtl/reg_cmd_parser.sv
// Host command parser: decodes read/write frames from a byte stream into single
// register-bus transactions and returns a reply byte stream.
module reg_cmd_parser #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  reply_data,
  output logic        reply_valid,
  input  logic        reply_ready,
  output logic [15:0] reg_addr,
  inout  wire  [31:0] reg_data,
  output logic        reg_wr,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WR, S_RD_SETUP, S_RD_SAMPLE, S_REPLY, S_ERR_REPLY
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          is_wr, is_wr_nxt;
  logic [15:0]   addr, addr_nxt;
  logic [31:0]   wdata, wdata_nxt;
  logic [31:0]   rbuf, rbuf_nxt;
  logic [2:0]    rcnt, rcnt_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [7:0]    err_nxt, reply_data_nxt;
  logic          reply_valid_nxt, cmd_ready_nxt, busy_nxt, reg_wr_nxt;
  logic [15:0]   reg_addr_nxt;
  logic          cmd_xfer, reply_xfer;
  logic [7:0]    err_inc;

  // The bus data lines are only ours during the single write cycle.
  assign reg_data = reg_wr ? wdata : 32'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      is_wr       <= 1'b0;
      addr        <= 16'h0000;
      wdata       <= 32'h0;
      rbuf        <= 32'h0;
      rcnt        <= 3'd0;
      timer       <= '0;
      err_count   <= 8'h00;
      reply_data  <= 8'h00;
      reply_valid <= 1'b0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      reg_wr      <= 1'b0;
      reg_addr    <= IDLE_ADDR;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      is_wr       <= is_wr_nxt;
      addr        <= addr_nxt;
      wdata       <= wdata_nxt;
      rbuf        <= rbuf_nxt;
      rcnt        <= rcnt_nxt;
      timer       <= timer_nxt;
      err_count   <= err_nxt;
      reply_data  <= reply_data_nxt;
      reply_valid <= reply_valid_nxt;
      cmd_ready   <= cmd_ready_nxt;
      busy        <= busy_nxt;
      reg_wr      <= reg_wr_nxt;
      reg_addr    <= reg_addr_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    is_wr_nxt       = is_wr;
    addr_nxt        = addr;
    wdata_nxt       = wdata;
    rbuf_nxt        = rbuf;
    rcnt_nxt        = rcnt;
    timer_nxt       = timer;
    err_nxt         = err_count;
    reply_data_nxt  = reply_data;
    reply_valid_nxt = reply_valid;
    cmd_xfer        = cmd_valid && cmd_ready;
    reply_xfer      = reply_valid && reply_ready;
    err_inc         = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

    case (state)
      S_IDLE: begin
        timer_nxt = '0;
        if (cmd_xfer) begin
          if (cmd_data == 8'h01 || cmd_data == 8'h02) begin
            is_wr_nxt = cmd_data[1];
            idx_nxt   = 2'd0;
            state_nxt = S_ADDR;
          end else begin
            err_nxt         = err_inc;
            reply_data_nxt  = 8'hFF;
            reply_valid_nxt = 1'b1;
            state_nxt       = S_ERR_REPLY;
          end
        end
      end
      S_ADDR, S_DATA: begin
        if (cmd_xfer) begin
          timer_nxt = '0;
          idx_nxt   = idx + 2'd1;
          if (state == S_ADDR) begin
            addr_nxt = (idx == 2'd0) ? {addr[15:8], cmd_data} : {cmd_data, addr[7:0]};
            if (idx == 2'd1) begin
              idx_nxt   = 2'd0;
              state_nxt = is_wr ? S_DATA : S_RD_SETUP;
            end
          end else begin
            wdata_nxt = {cmd_data, wdata[31:8]};
            if (idx == 2'd3) state_nxt = S_WR;
          end
        end else if (timer == TW'(TIMEOUT - 1)) begin
          // Partial frame abandoned: count it and drop silently.
          timer_nxt = '0;
          err_nxt   = err_inc;
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_WR: begin
        reply_data_nxt  = 8'h02;
        reply_valid_nxt = 1'b1;
        rcnt_nxt        = 3'd0;
        state_nxt       = S_REPLY;
      end
      S_RD_SETUP: state_nxt = S_RD_SAMPLE;
      S_RD_SAMPLE: begin
        rbuf_nxt        = reg_data;
        reply_data_nxt  = 8'h01;
        reply_valid_nxt = 1'b1;
        rcnt_nxt        = 3'd0;
        state_nxt       = S_REPLY;
      end
      S_REPLY: begin
        if (reply_xfer) begin
          if (!is_wr && rcnt != 3'd4) begin
            reply_data_nxt = rbuf[7:0];
            rbuf_nxt       = {8'h00, rbuf[31:8]};
            rcnt_nxt       = rcnt + 3'd1;
          end else begin
            reply_valid_nxt = 1'b0;
            state_nxt       = S_IDLE;
          end
        end
      end
      S_ERR_REPLY: begin
        if (reply_xfer) begin
          reply_valid_nxt = 1'b0;
          state_nxt       = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    cmd_ready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_ADDR) || (state_nxt == S_DATA);
    busy_nxt      = (state_nxt != S_IDLE);
    reg_wr_nxt    = (state_nxt == S_WR);
    reg_addr_nxt  = ((state_nxt == S_WR) || (state_nxt == S_RD_SETUP) ||
                     (state_nxt == S_RD_SAMPLE)) ? addr_nxt : IDLE_ADDR;
  end

endmodule

// File: tb/tb_reg_cmd_parser.sv
// Directed bench for reg_cmd_parser with a single behavioural register at address 5.
module tb_reg_cmd_parser;

  localparam int unsigned TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  reply_data;
  logic        reply_valid;
  logic        reply_ready;
  logic [15:0] reg_addr;
  wire  [31:0] reg_data;
  logic        reg_wr;
  logic        busy;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;
  int wr_double = 0;
  logic prev_wr = 1'b0;
  logic [31:0] mem5 = 32'h0;

  reg_cmd_parser #(.TIMEOUT(TIMEOUT), .IDLE_ADDR(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .reply_data(reply_data), .reply_valid(reply_valid), .reply_ready(reply_ready),
    .reg_addr(reg_addr), .reg_data(reg_data), .reg_wr(reg_wr),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Register model at address 5: drives the bus on reads, latches on writes.
  assign reg_data = (reg_addr == 16'h0005 && !reg_wr) ? mem5 : 32'bz;
  always @(posedge clk) if (reg_wr === 1'b1 && reg_addr == 16'h0005) mem5 <= reg_data;

  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      wr_pulses++;
      if (prev_wr) wr_double++;
    end
    prev_wr = (reg_wr === 1'b1);
  end

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n = 0;
    reply_ready = 1'b1;
    while (reply_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (reply_valid !== 1'b1) begin
      errors++;
      $display("FAIL recv_byte timeout: reply_valid=%b required 1", reply_valid);
    end
    b = reply_data;
    @(negedge clk);
    reply_ready = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input string name);
    logic [7:0] b;
    send_byte(8'h02); send_byte(a[7:0]); send_byte(a[15:8]);
    send_byte(d[7:0]); send_byte(d[15:8]); send_byte(d[23:16]); send_byte(d[31:24]);
    checks++;
    if (reg_wr !== 1'b1 || reg_addr !== a || reg_data !== d) begin
      errors++;
      $display("FAIL %s wr cycle: wr=%b addr=%h data=%h required 1 %h %h", name, reg_wr, reg_addr, reg_data, a, d);
    end
    @(negedge clk);
    checks++;
    if (reply_valid !== 1'b1 || reply_data !== 8'h02 || reg_wr !== 1'b0) begin
      errors++;
      $display("FAIL %s reply latency: valid=%b data=%h wr=%b required 1 02 0", name, reply_valid, reply_data, reg_wr);
    end
    recv_byte(b);
    checks++;
    if (b !== 8'h02 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s done: reply=%h busy=%b cmd_ready=%b required 02 0 1", name, b, busy, cmd_ready);
    end
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] exp, input string name);
    logic [7:0] b;
    logic [39:0] got, want;
    int wr0 = wr_pulses;
    send_byte(8'h01); send_byte(a[7:0]); send_byte(a[15:8]);
    checks++;
    if (reg_addr !== a || reg_wr !== 1'b0 || reply_valid !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s setup: addr=%h wr=%b rv=%b busy=%b cr=%b required %h 0 0 1 0", name, reg_addr, reg_wr, reply_valid, busy, cmd_ready, a);
    end
    @(negedge clk);
    checks++;
    if (reg_addr !== a || reg_data !== exp || reply_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s sample: addr=%h data=%h rv=%b required %h %h 0", name, reg_addr, reg_data, reply_valid, a, exp);
    end
    @(negedge clk);
    checks++;
    if (reply_valid !== 1'b1 || reg_addr !== 16'h0000) begin
      errors++;
      $display("FAIL %s reply latency: rv=%b addr=%h required 1 0000", name, reply_valid, reg_addr);
    end
    got = '0;
    for (int i = 0; i < 5; i++) begin
      recv_byte(b);
      got = {got[31:0], b};
    end
    want = {8'h01, exp[7:0], exp[15:8], exp[23:16], exp[31:24]};
    checks++;
    if (got !== want || wr_pulses != wr0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s reply: got=%h busy=%b wr_pulses+%0d required %h 0 +0", name, got, busy, wr_pulses - wr0, want);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (cmd_ready !== 1'b0 || reply_valid !== 1'b0 || reply_data !== 8'h00 || reg_addr !== 16'h0000 ||
        reg_wr !== 1'b0 || busy !== 1'b0 || err_count !== 8'h00) begin
      errors++;
      $display("FAIL reset values: cr=%b rv=%b rd=%h addr=%h wr=%b busy=%b err=%h required 0 0 00 0000 0 0 00",
               cmd_ready, reply_valid, reply_data, reg_addr, reg_wr, busy, err_count);
    end
  endtask

  task automatic test_write();
    int wr0 = wr_pulses;
    do_write(16'h0005, 32'hDEADBEEF, "write1");
    checks++;
    if (wr_pulses != wr0 + 1 || mem5 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write1 effect: pulses+%0d mem5=%h required +1 deadbeef", wr_pulses - wr0, mem5);
    end
  endtask

  task automatic test_read();
    do_read(16'h0005, 32'hDEADBEEF, "read1");
  endtask

  task automatic test_bad_opcode();
    logic [7:0] b;
    int wr0 = wr_pulses;
    send_byte(8'h7A);
    checks++;
    if (reg_addr !== 16'h0000 || busy !== 1'b1 || cmd_ready !== 1'b0 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL badop state: addr=%h busy=%b cr=%b err=%0d required 0000 1 0 1", reg_addr, busy, cmd_ready, err_count);
    end
    recv_byte(b);
    checks++;
    if (b !== 8'hFF || wr_pulses != wr0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL badop reply: got=%h pulses+%0d busy=%b required ff +0 0", b, wr_pulses - wr0, busy);
    end
    do_read(16'h0005, 32'hDEADBEEF, "read_after_err");
  endtask

  task automatic test_timeout();
    int wr0 = wr_pulses;
    send_byte(8'h02); send_byte(8'h05);
    repeat (TIMEOUT - 2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || err_count !== 8'd1 || reply_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout early: busy=%b err=%0d rv=%b required 1 1 0", busy, err_count, reply_valid);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err_count !== 8'd2 || reply_valid !== 1'b0 || wr_pulses != wr0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout abort: busy=%b err=%0d rv=%b pulses+%0d cr=%b required 0 2 0 +0 1",
               busy, err_count, reply_valid, wr_pulses - wr0, cmd_ready);
    end
    do_write(16'h0005, 32'h12345678, "write_after_timeout");
    checks++;
    if (mem5 !== 32'h12345678) begin
      errors++;
      $display("FAIL write_after_timeout mem5: got %h required 12345678", mem5);
    end
  endtask

  task automatic test_reply_stall();
    logic [39:0] got = '0;
    int nbytes = 0;
    int n = 0;
    int held = 0;
    int stall_errs = 0;
    logic [7:0] held_data = 8'h00;
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h00);
    while (nbytes < 5 && n < 80) begin
      if (held != 0 && (reply_valid !== 1'b1 || reply_data !== held_data)) stall_errs++;
      if (reply_valid === 1'b1 && cmd_ready !== 1'b0) stall_errs++;
      reply_ready = (n % 3 == 0);
      held = 0;
      if (reply_valid === 1'b1) begin
        if (reply_ready) begin
          got = {got[31:0], reply_data};
          nbytes++;
        end else begin
          held = 1;
          held_data = reply_data;
        end
      end
      n++;
      @(negedge clk);
    end
    reply_ready = 1'b0;
    checks++;
    if (got !== 40'h01_78_56_34_12 || nbytes != 5) begin
      errors++;
      $display("FAIL stall reply order: got=%h n=%0d required 0178563412 5", got, nbytes);
    end
    checks++;
    if (stall_errs != 0) begin
      errors++;
      $display("FAIL stall stability: %0d violations required 0", stall_errs);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall end: cr=%b busy=%b required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int wr0 = wr_pulses;
    int bad = 0;
    send_byte(8'h02); send_byte(8'h05); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_pulses != wr0 || mem5 !== 32'h12345678 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset mid frame: pulses+%0d mem5=%h busy=%b required +0 12345678 0", wr_pulses - wr0, mem5, busy);
    end
    for (int i = 0; i < 255; i++) begin
      send_byte(8'h7A);
      recv_byte(b);
      if (b !== 8'hFF) bad++;
    end
    checks++;
    if (err_count !== 8'd255 || bad != 0) begin
      errors++;
      $display("FAIL err count fill: err=%0d bad_replies=%0d required 255 0", err_count, bad);
    end
    send_byte(8'h33);
    recv_byte(b);
    checks++;
    if (err_count !== 8'd255 || b !== 8'hFF) begin
      errors++;
      $display("FAIL err saturate: err=%0d reply=%h required 255 ff", err_count, b);
    end
  endtask

  task automatic test_bus_rules();
    checks++;
    if (wr_double != 0 || wr_pulses != 2) begin
      errors++;
      $display("FAIL bus rules: double=%0d pulses=%0d required 0 2", wr_double, wr_pulses);
    end
  endtask

  initial begin
    reset       = 1'b1;
    cmd_data    = 8'h00;
    cmd_valid   = 1'b0;
    reply_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_write();
    test_read();
    test_bad_opcode();
    test_timeout();
    test_reply_stall();
    test_reset_mid_frame();
    test_bus_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
